slice_adder: RTL and testbench

SLICE_ADDER -- requirements
Module: slice_adder

---
 rtl/slice_adder.sv | 139 +++++++++++++
 tb/tb_slice_adder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_adder.sv
// Bit-serial-by-slice adder: adds SLICE bits of a and b per clock, starting from bit 0.
// Define SLICE_ADDER_OVF_EN to add the signed-overflow output ovf.
module slice_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SLICE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | one slice of the latched operands added per cycle
    // DONE  | single-cycle result-valid pulse; a new start is accepted here too

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef SLICE_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [SLICE-1:0]   a_slc, b_slc;
    logic [SLICE:0]     slice_sum;
    logic               last_slice;

    always_comb begin
        a_slc      = a_q[int'(k_q)*SLICE +: SLICE];
        b_slc      = b_q[int'(k_q)*SLICE +: SLICE];
        slice_sum  = {1'b0, a_slc} + {1'b0, b_slc} + {{SLICE{1'b0}}, carry_q};
        last_slice = (k_q == KW'(N - 1));

        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SLICE_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    k_d     = '0;
                    carry_d = cin;
                    if (en) begin
                        state_d = RUN;
                    end else begin
                        // pass-through completes immediately; no RUN cycles
                        state_d = DONE;
                        sum_d   = a;
                        cout_d  = 1'b0;
`ifdef SLICE_ADDER_OVF_EN
                        ovf_d   = 1'b0;
`endif
                    end
                end
            end
            RUN: begin
                sum_d[int'(k_q)*SLICE +: SLICE] = slice_sum[SLICE-1:0];
                carry_d = slice_sum[SLICE];
                k_d     = k_q + KW'(1);
                if (last_slice) begin
                    state_d = DONE;
                    cout_d  = slice_sum[SLICE];
`ifdef SLICE_ADDER_OVF_EN
                    // same-sign operands giving an opposite-sign result
                    ovf_d   = (a_slc[SLICE-1] == b_slc[SLICE-1]) &&
                              (slice_sum[SLICE-1] != a_slc[SLICE-1]);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SLICE_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SLICE_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SLICE_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_slice_adder.sv
// Testbench for slice_adder: directed vectors plus a cycle-level arithmetic reference model.
// Checks ovf as well when built with SLICE_ADDER_OVF_EN.
module tb_slice_adder;

    logic        clk = 1'b0;
    logic        rst, start, en, cin;
    logic [15:0] a, b;
    logic        busy, done, cout;
    logic [15:0] sum;

    logic        start8, en8, cin8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;
`ifdef SLICE_ADDER_OVF_EN
    logic        ovf, ovf8;
`endif

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 0;

    always #5 clk = ~clk;

    slice_adder #(.WIDTH(16), .SLICE(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .en    (en),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SLICE_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    slice_adder #(.WIDTH(8), .SLICE(1)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .en    (en8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
`ifdef SLICE_ADDER_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    // Reference: result is plain (a+b+cin), it appears N+1 cycles after acceptance for
    // an add, one cycle after for a pass-through; starts are ignored while running.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_sum  = '0;
    logic        m_cout = 1'b0;
    logic        m_ovf  = 1'b0;
    logic [15:0] p_sum;
    logic        p_cout, p_ovf;

    always @(posedge clk) begin
        logic [16:0] r;
        logic        nd;
        nd = 1'b0;
        if (rst) begin
            m_left = 0;
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                nd     = 1'b1;
                m_sum  = p_sum;
                m_cout = p_cout;
                m_ovf  = p_ovf;
            end
        end else if (start) begin
            if (en) begin
                r      = {1'b0, a} + {1'b0, b} + {16'd0, cin};
                p_sum  = r[15:0];
                p_cout = r[16];
                p_ovf  = (a[15] == b[15]) && (r[15] != a[15]);
                m_left = 4;
            end else begin
                nd     = 1'b1;
                m_sum  = a;
                m_cout = 1'b0;
                m_ovf  = 1'b0;
            end
        end
        m_done = nd;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit ok;
            ok = (busy == (m_left > 0)) && (done == m_done) &&
                 (busy || (sum == m_sum && cout == m_cout));
`ifdef SLICE_ADDER_OVF_EN
            ok = ok && (busy || ovf == m_ovf);
`endif
            n_total++;
            if (ok) n_pass++;
            else $display("FAIL model_cmp t=%0t busy=%b exp=%b done=%b exp=%b sum=%h exp=%h cout=%b exp=%b",
                          $time, busy, (m_left > 0), done, m_done, sum, m_sum, cout, m_cout);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    endtask

    // Called at a falling edge; drives one start and waits (bounded) for done.
    task automatic run_op(input string nm, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tc, input logic te, input logic [15:0] xs,
                          input logic xc, input logic xo, input int xbusy, input bit glitch);
        int cyc, bcnt;
        a = ta; b = tb_v; cin = tc; en = te; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; bcnt = 0;
        while (!done && cyc < 40) begin
            if (busy) bcnt++;
            if (glitch && cyc == 1) begin
                start = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
            end else if (glitch && cyc == 2) begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk({nm, " done_seen"}, 32'(done), 32'd1);
        chk({nm, " latency"}, 32'(cyc), 32'(xbusy));
        chk({nm, " busy_cycles"}, 32'(bcnt), 32'(xbusy));
        chk({nm, " sum"}, 32'(sum), 32'(xs));
        chk({nm, " cout"}, 32'(cout), 32'(xc));
        chk({nm, " model_sum"}, 32'(m_sum), 32'(xs));
`ifdef SLICE_ADDER_OVF_EN
        chk({nm, " ovf"}, 32'(ovf), 32'(xo));
`else
        if (xo) chk({nm, " model_ovf"}, 32'(m_ovf), 32'(xo));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [15:0] st_a [4] = '{16'h1111, 16'h8000, 16'hABCD, 16'hFFFF};
    logic [15:0] st_b [4] = '{16'h2222, 16'h8000, 16'h1234, 16'hFFFF};
    logic        st_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] st_s [4] = '{16'h3333, 16'h0000, 16'hBE01, 16'hFFFF};
    logic        st_o [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int cyc, bcnt;
        rst = 1'b1; start = 1'b0; en = 1'b0; cin = 1'b0; a = '0; b = '0;
        start8 = 1'b0; en8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst sum", 32'(sum), 32'd0);
        chk("rst cout", 32'(cout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 4, 0);
        @(negedge clk);
        chk("wrap done_one_cycle", 32'(done), 32'd0);
        run_op("pass", 16'h1234, 16'hFFFF, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        chk("pass done_one_cycle", 32'(done), 32'd0);
        run_op("ignore", 16'h0F0F, 16'h0101, 1'b1, 1'b1, 16'h1011, 1'b0, 1'b0, 4, 1);
        @(negedge clk);
        run_op("carry8", 16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 4, 0);
        @(negedge clk);
        run_op("cin_only", 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 4, 0);
        @(negedge clk);
        run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 4, 0);
        @(negedge clk);
        run_op("ovf_none", 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 4, 0);
        @(negedge clk);

        // reset during the second RUN cycle abandons the operation
        a = 16'h1234; b = 16'h1111; cin = 1'b0; en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort sum", 32'(sum), 32'd0);
        rst = 1'b0;
        run_op("after_rst", 16'h0002, 16'h0003, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 4, 0);
        @(negedge clk);

        // start held high: back-to-back operations, done every 5 cycles
        a = st_a[0]; b = st_b[0]; cin = st_c[0]; en = 1'b1; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!done && cyc < 40);
            chk($sformatf("stream%0d period", i), 32'(cyc), 32'd5);
            chk($sformatf("stream%0d sum", i), 32'(sum), 32'(st_s[i]));
            chk($sformatf("stream%0d cout", i), 32'(cout), 32'(st_o[i]));
            if (i < 3) begin
                a = st_a[i+1]; b = st_b[i+1]; cin = st_c[i+1];
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk("stream done_drop", 32'(done), 32'd0);

        // 8-bit, 1-bit-slice instance
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; en8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0; bcnt = 0;
        while (!done8 && cyc < 40) begin
            if (busy8) bcnt++;
            @(negedge clk);
            cyc++;
        end
        chk("w8 done_seen", 32'(done8), 32'd1);
        chk("w8 busy_cycles", 32'(bcnt), 32'd8);
        chk("w8 sum", 32'(sum8), 32'd0);
        chk("w8 cout", 32'(cout8), 32'd1);
`ifdef SLICE_ADDER_OVF_EN
        chk("w8 ovf", 32'(ovf8), 32'd0);
`endif
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
